sd_host_arbiter: RTL and testbench

Shares the single host-side block-I/O channel (lba, rd/wr strobes, ack, buffer-write path) between up to four virtual SD card instances in `clk_sys`. It performs round-robin arbitration across the requesters and holds one transaction at a time. It routes the host ack and buffer traffic only to the granted requester. An optional timeout aborts requests the host never acknowledges.

---
 rtl/sd_host_arbiter.sv | 161 ++++++++++++++++
 tb/tb_sd_host_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/sd_host_arbiter.sv
// Round-robin arbiter sharing one host block-I/O channel between NUM virtual SD cards.
// Optional ISSUE timeout abort is enabled with the macro SD_HOST_ARB_TIMEOUT_EN.
module sd_host_arbiter #(
  parameter int          NUM     = 2,
  parameter int          GAP     = 8,
  parameter logic [23:0] TIMEOUT = 24'd12_000_000
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic [NUM*32-1:0] req_lba,
  input  logic [NUM-1:0]    req_rd,
  input  logic [NUM-1:0]    req_wr,
  output logic [NUM-1:0]    req_ack,
  output logic [NUM-1:0]    req_err,
  input  logic [NUM*8-1:0]  req_buff_din,
  output logic [31:0]       host_lba,
  output logic              host_rd,
  output logic              host_wr,
  input  logic              host_ack,
  output logic [7:0]        host_buff_din,
  output logic [NUM-1:0]    grant,
  output logic              busy
);
  localparam int PW = (NUM > 2) ? 2 : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_XFER, S_GAP} state_t;

  state_t          state, state_nxt;
  logic            ack_q, ack_rise, ack_fall;
  logic [PW-1:0]   ptr, ptr_nxt, gidx, gidx_nxt, win, ptr_adv;
  logic [NUM-1:0]  pend, grant_nxt;
  logic [31:0]     lba_nxt;
  logic            rd_nxt, wr_nxt, found, tmo_hit;
  logic [3:0]      gap_cnt, gap_nxt;

  assign ack_rise = host_ack & ~ack_q;
  assign ack_fall = ~host_ack & ack_q;
  assign busy     = (state != S_IDLE);
  assign ptr_adv  = (gidx == PW'(NUM-1)) ? '0 : gidx + PW'(1);

  // Walk from the highest offset down so the lowest offset from ptr wins.
  always_comb begin
    int idx;
    idx   = 0;
    pend  = req_rd | req_wr;
    win   = '0;
    found = 1'b0;
    for (int k = NUM-1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NUM;
      if (pend[idx]) begin
        win   = PW'(idx);
        found = 1'b1;
      end
    end
  end

  always_comb begin
    host_buff_din = 8'h00;
    for (int i = 0; i < NUM; i++)
      if (grant[i]) host_buff_din = host_buff_din | req_buff_din[i*8 +: 8];
  end

`ifdef SD_HOST_ARB_TIMEOUT_EN
  logic [23:0]    tmo_cnt;
  logic [NUM-1:0] err_q;

  assign tmo_hit = (state == S_ISSUE) && !ack_rise && (tmo_cnt == TIMEOUT - 24'd1);
  assign req_err = err_q;
  // The abort cycle also presents an ack so the requester's handshake completes.
  assign req_ack = (grant & {NUM{host_ack}}) | err_q;

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      tmo_cnt <= '0;
      err_q   <= '0;
    end else begin
      tmo_cnt <= (state == S_ISSUE) ? tmo_cnt + 24'd1 : '0;
      err_q   <= tmo_hit ? grant : '0;
    end
  end
`else
  assign tmo_hit = 1'b0;
  assign req_err = '0;
  assign req_ack = grant & {NUM{host_ack}};
`endif

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    gidx_nxt  = gidx;
    grant_nxt = grant;
    lba_nxt   = host_lba;
    rd_nxt    = host_rd;
    wr_nxt    = host_wr;
    gap_nxt   = gap_cnt;
    case (state)
      S_IDLE: begin
        if (found) begin
          grant_nxt = NUM'(1) << win;
          gidx_nxt  = win;
          lba_nxt   = req_lba[int'(win)*32 +: 32];
          rd_nxt    = req_rd[win];
          wr_nxt    = req_wr[win] & ~req_rd[win];
          state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (ack_rise) begin
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          state_nxt = S_XFER;
        end else if (tmo_hit) begin
          rd_nxt    = 1'b0;
          wr_nxt    = 1'b0;
          grant_nxt = '0;
          ptr_nxt   = ptr_adv;
          gap_nxt   = 4'(GAP);
          state_nxt = S_GAP;
        end
      end
      S_XFER: begin
        if (ack_fall) begin
          grant_nxt = '0;
          ptr_nxt   = ptr_adv;
          gap_nxt   = 4'(GAP);
          state_nxt = S_GAP;
        end
      end
      S_GAP: begin
        // Leave on the last counted cycle so IDLE lands exactly GAP cycles after entry.
        gap_nxt = (gap_cnt == 4'd0) ? 4'd0 : gap_cnt - 4'd1;
        if (gap_cnt <= 4'd1) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      ack_q    <= 1'b0;
      ptr      <= '0;
      gidx     <= '0;
      grant    <= '0;
      host_lba <= '0;
      host_rd  <= 1'b0;
      host_wr  <= 1'b0;
      gap_cnt  <= '0;
    end else begin
      state    <= state_nxt;
      ack_q    <= host_ack;
      ptr      <= ptr_nxt;
      gidx     <= gidx_nxt;
      grant    <= grant_nxt;
      host_lba <= lba_nxt;
      host_rd  <= rd_nxt;
      host_wr  <= wr_nxt;
      gap_cnt  <= gap_nxt;
    end
  end
endmodule

// File: tb/tb_sd_host_arbiter.sv
// Directed bench for sd_host_arbiter with NUM=2, GAP=8 (timeout steps need SD_HOST_ARB_TIMEOUT_EN).
module tb_sd_host_arbiter;
  localparam int NUM = 2;
  localparam int GAP = 8;

  logic              clk_sys = 1'b0;
  logic              reset_n;
  logic [NUM*32-1:0] req_lba;
  logic [NUM-1:0]    req_rd, req_wr, req_ack, req_err, grant;
  logic [NUM*8-1:0]  req_buff_din;
  logic [31:0]       host_lba;
  logic              host_rd, host_wr, host_ack, busy;
  logic [7:0]        host_buff_din;

  int checks   = 0;
  int failures = 0;

  sd_host_arbiter #(.NUM(NUM), .GAP(GAP), .TIMEOUT(24'd100)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .req_lba(req_lba), .req_rd(req_rd),
    .req_wr(req_wr), .req_ack(req_ack), .req_err(req_err), .req_buff_din(req_buff_din),
    .host_lba(host_lba), .host_rd(host_rd), .host_wr(host_wr), .host_ack(host_ack),
    .host_buff_din(host_buff_din), .grant(grant), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Ack held for n sampled cycles; clears the given request bits once the host has acked.
  task automatic do_ack(input int n, input logic [NUM-1:0] clr_rd, input logic [NUM-1:0] clr_wr);
    host_ack = 1'b1;
    tick();
    req_rd = req_rd & ~clr_rd;
    req_wr = req_wr & ~clr_wr;
    repeat (n-1) tick();
    host_ack = 1'b0;
    tick();
    check("grant_clear_after_fall", 32'(grant), 32'h0);
  endtask

  task automatic wait_grant(input string tag, input logic [NUM-1:0] exp);
    int cnt;
    cnt = 0;
    while (grant == '0 && cnt < 40) begin
      tick();
      cnt++;
    end
    check({tag, "_grant"}, 32'(grant), 32'(exp));
    check({tag, "_spacing"}, 32'(cnt), 32'(GAP+1));
  endtask

  initial begin
    reset_n = 1'b0; req_lba = '0; req_rd = '0; req_wr = '0; host_ack = 1'b0;
    req_buff_din = {8'h5A, 8'hA5};
    tick(); tick();
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_strobes", {30'd0, host_rd, host_wr}, 32'h0);
    check("rst_lba", host_lba, 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_buff", 32'(host_buff_din), 32'h0);
    reset_n = 1'b1;
    tick();

    // single read on requester 0
    req_lba = {32'h0000_BEEF, 32'h0000_1234};
    req_rd  = 2'b01;
    tick();
    check("r0_grant", 32'(grant), 32'h1);
    check("r0_rd", {30'd0, host_rd, host_wr}, 32'h2);
    check("r0_lba", host_lba, 32'h0000_1234);
    check("r0_buff", 32'(host_buff_din), 32'hA5);
    check("r0_busy", 32'(busy), 32'h1);
    host_ack = 1'b1;
    #1 check("r0_ack_comb", 32'(req_ack), 32'h1);
    tick();
    check("r0_rd_drop", 32'(host_rd), 32'h0);
    req_rd = 2'b00;
    for (int i = 0; i < 4; i++) begin
      check("r0_ack_hold", 32'(req_ack), 32'h1);
      tick();
    end
    host_ack = 1'b0;
    #1 check("r0_ack_low", 32'(req_ack), 32'h0);
    tick();
    check("r0_fall_grant", 32'(grant), 32'h0);
    req_rd = 2'b10;
    repeat (GAP) tick();
    check("gap_end_busy", 32'(busy), 32'h0);
    check("gap_end_grant", 32'(grant), 32'h0);
    tick();
    check("r1_grant", 32'(grant), 32'h2);
    check("r1_lba", host_lba, 32'h0000_BEEF);
    check("r1_buff", 32'(host_buff_din), 32'h5A);

    // both reading continuously: alternation
    req_rd = 2'b11;
    do_ack(2, 2'b00, 2'b00);
    wait_grant("alt1", 2'b01);
    do_ack(2, 2'b00, 2'b00);
    wait_grant("alt2", 2'b10);
    do_ack(2, 2'b00, 2'b00);
    wait_grant("alt3", 2'b01);
    req_rd = 2'b00;
    do_ack(2, 2'b00, 2'b00);
    repeat (GAP) tick();
    check("idle_busy", 32'(busy), 32'h0);
    check("idle_buff", 32'(host_buff_din), 32'h0);
    host_ack = 1'b1;
    #1 check("idle_ack_ignored", 32'(req_ack), 32'h0);
    host_ack = 1'b0;
    tick();

    // read and write together on requester 1: read first, then write
    req_lba[63:32] = 32'h0000_CAFE;
    req_rd = 2'b10; req_wr = 2'b10;
    tick();
    check("rw_grant", 32'(grant), 32'h2);
    check("rw_read_first", {30'd0, host_rd, host_wr}, 32'h2);
    do_ack(3, 2'b10, 2'b00);
    wait_grant("rw_wr", 2'b10);
    check("rw_write_second", {30'd0, host_rd, host_wr}, 32'h1);
    check("rw_lba", host_lba, 32'h0000_CAFE);
    do_ack(2, 2'b00, 2'b10);

    // requester 0 completes so ptr = 1, then reset mid-transfer of requester 1
    req_lba[31:0] = 32'h0000_0077;
    req_rd = 2'b01;
    wait_grant("p0", 2'b01);
    check("p0_lba", host_lba, 32'h0000_0077);
    do_ack(2, 2'b01, 2'b00);
    req_wr = 2'b10;
    wait_grant("p1", 2'b10);
    host_ack = 1'b1;
    tick();
    check("p1_xfer_wr_drop", 32'(host_wr), 32'h0);
    reset_n = 1'b0;
    tick();
    check("mid_rst_grant", 32'(grant), 32'h0);
    check("mid_rst_lba", host_lba, 32'h0);
    check("mid_rst_busy", 32'(busy), 32'h0);
    check("mid_rst_ack", 32'(req_ack), 32'h0);
    check("mid_rst_strobes", {30'd0, host_rd, host_wr}, 32'h0);
    reset_n = 1'b1; host_ack = 1'b0;
    req_wr = 2'b11;
    tick();
    check("post_rst_ptr0", 32'(grant), 32'h1);
    check("post_rst_wr", {30'd0, host_rd, host_wr}, 32'h1);
    check("post_rst_lba", host_lba, 32'h0000_0077);
    do_ack(2, 2'b00, 2'b01);
    wait_grant("post_rst_next", 2'b10);
    check("post_rst_next_lba", host_lba, 32'h0000_CAFE);
    do_ack(2, 2'b00, 2'b10);
    repeat (GAP + 1) tick();

`ifdef SD_HOST_ARB_TIMEOUT_EN
    begin
      int cnt;
      req_rd = 2'b01;
      tick();
      check("tmo_grant", 32'(grant), 32'h1);
      cnt = 0;
      while (req_err == '0 && cnt < 200) begin
        tick();
        cnt++;
      end
      req_rd = 2'b00;
      check("tmo_cycles", 32'(cnt), 32'd100);
      check("tmo_err", 32'(req_err), 32'h1);
      check("tmo_ack", 32'(req_ack), 32'h1);
      check("tmo_grant_clr", 32'(grant), 32'h0);
      check("tmo_strobes", {30'd0, host_rd, host_wr}, 32'h0);
      tick();
      check("tmo_err_pulse", 32'(req_err), 32'h0);
      host_ack = 1'b1;
      #1 check("tmo_late_ack", 32'(req_ack), 32'h0);
      tick();
      check("tmo_late_ack_hold", 32'(req_ack), 32'h0);
      host_ack = 1'b0;
    end
`else
    check("no_tmo_err", 32'(req_err), 32'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
